fp_normalize: RTL

FP_NORMALIZE -- requirements
Module: fp_normalize

---
 rtl/fp_normalize.sv | 231 +++++++++++++++++++++++
 1 files changed

// File: rtl/fp_normalize.sv
// ============================================================================
// fp_normalize
// ----------------------------------------------------------------------------
// Post add/sub normalizer for a single-precision style datapath. The raw
// magnitude arrives with a carry position at bit 28, the hidden-one position
// at bit 27 and guard/round/sticky in bits 3:0. The block shifts the
// magnitude so the leading one sits at bit 27. It adjusts the biased exponent
// to match and raises flags for overflow, denormal results and a zero
// magnitude. The result then goes to the rounding stage.
//
// Normalization is iterative, one left shift per clock. A carry is fixed with
// a single right shift.
//
// Optional feature (compile-time macro FP_NORM_STICKY_EN):
//   defined   : the bit lost by the carry right shift is ORed into bit 0
//   undefined : the bit lost by the carry right shift is dropped
//
// Ports
//   clk       in   1   clock, rising edge
//   reset     in   1   asynchronous active-high reset
//   start     in   1   load operands and begin (honoured only in IDLE)
//   a_in      in  29   raw magnitude {carry, hidden, fraction, g/r/s}
//   exp_in    in   8   biased exponent of the raw result
//   sign_in   in   1   result sign
//   busy      out  1   high while in SCAN or DONE
//   done      out  1   single-cycle pulse, outputs valid
//   a_out     out 29   normalized magnitude, leading one at bit 27
//   msb_loc   out  5   leading-one index of a_in (clamped to 27, 0 if zero)
//   exp_out   out  8   adjusted exponent
//   sign_out  out  1   registered sign
//   flags     out  3   {ovf, denorm, zero}
// ============================================================================
module fp_normalize (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [28:0] a_in,
    input  logic [7:0]  exp_in,
    input  logic        sign_in,
    output logic        busy,
    output logic        done,
    output logic [28:0] a_out,
    output logic [4:0]  msb_loc,
    output logic [7:0]  exp_out,
    output logic        sign_out,
    output logic [2:0]  flags
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;

    logic [28:0] mant_q,   mant_d;
    logic [7:0]  exp_q,    exp_d;
    logic [4:0]  msb_q,    msb_d;
    logic        sign_q,   sign_d;
    logic        ovf_q,    ovf_d;
    logic        denorm_q, denorm_d;
    logic        zero_q,   zero_d;

    logic [4:0]  leadIdx;
    logic [28:0] rightShift;
    logic [28:0] leftShift;
    logic        scanFinish;

    // Leading-one index of the incoming operand. A set carry bit is
    // reported as 27, because after the carry shift the leading one sits
    // there. The later, higher matches override the lower ones.
    always_comb begin
        leadIdx = 5'd0;
        for (int i = 0; i < 28; i++) begin
            if (a_in[i]) begin
                leadIdx = 5'(i);
            end
        end
        if (a_in[28]) begin
            leadIdx = 5'd27;
        end
    end

    // Shift candidates for the SCAN rules. When the sticky option is on,
    // the bit lost off the bottom by the carry shift is folded into the new
    // LSB.
    always_comb begin
        rightShift = {1'b0, mant_q[28:1]};
`ifdef FP_NORM_STICKY_EN
        rightShift[0] = mant_q[1] | mant_q[0];
`endif
        leftShift = {mant_q[27:0], 1'b0};
    end

    // Any rule except the plain left shift ends the scan this cycle.
    assign scanFinish = (mant_q == 29'd0) | mant_q[28] | mant_q[27] |
                        (exp_q <= 8'd1);

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic. start is looked at only in IDLE, so a request made
    // while busy (including the DONE cycle) is dropped.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = SCAN;
                end
            end
            SCAN: begin
                if (scanFinish) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // FSM outputs.
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state_q)
            SCAN: begin
                busy = 1'b1;
            end
            DONE: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: begin
                busy = 1'b0;
                done = 1'b0;
            end
        endcase
    end

    // Datapath next-state. IDLE+start loads the operands. SCAN applies the
    // first rule that matches. The exponent stops at 1 on the way down,
    // because the denorm rule catches it before the decrement. On the way
    // up it saturates at 255 with ovf raised. Outside these cases the
    // registers hold, so the result stays visible after DONE.
    always_comb begin
        mant_d   = mant_q;
        exp_d    = exp_q;
        msb_d    = msb_q;
        sign_d   = sign_q;
        ovf_d    = ovf_q;
        denorm_d = denorm_q;
        zero_d   = zero_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    mant_d   = a_in;
                    exp_d    = exp_in;
                    sign_d   = sign_in;
                    msb_d    = leadIdx;
                    ovf_d    = 1'b0;
                    denorm_d = 1'b0;
                    zero_d   = 1'b0;
                end
            end
            SCAN: begin
                if (mant_q == 29'd0) begin
                    zero_d = 1'b1;
                    exp_d  = 8'd0;
                end else if (mant_q[28]) begin
                    mant_d = rightShift;
                    if (exp_q >= 8'd254) begin
                        ovf_d = 1'b1;
                        exp_d = 8'd255;
                    end else begin
                        exp_d = exp_q + 8'd1;
                    end
                end else if (mant_q[27]) begin
                    mant_d = mant_q;
                end else if (exp_q <= 8'd1) begin
                    denorm_d = 1'b1;
                end else begin
                    mant_d = leftShift;
                    exp_d  = exp_q - 8'd1;
                end
            end
            default: begin
                mant_d = mant_q;
            end
        endcase
    end

    // Datapath registers. Reset clears every visible result immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mant_q   <= 29'd0;
            exp_q    <= 8'd0;
            msb_q    <= 5'd0;
            sign_q   <= 1'b0;
            ovf_q    <= 1'b0;
            denorm_q <= 1'b0;
            zero_q   <= 1'b0;
        end else begin
            mant_q   <= mant_d;
            exp_q    <= exp_d;
            msb_q    <= msb_d;
            sign_q   <= sign_d;
            ovf_q    <= ovf_d;
            denorm_q <= denorm_d;
            zero_q   <= zero_d;
        end
    end

    assign a_out    = mant_q;
    assign exp_out  = exp_q;
    assign msb_loc  = msb_q;
    assign sign_out = sign_q;
    assign flags    = {ovf_q, denorm_q, zero_q};

endmodule
